// File: rtl/be_native_mem.sv
`default_nettype none
// ============================================================================
// be_native_mem : native-interface memory responder with byte-strobed writes
//                 and fixed read/write latency. Optional BE_MEM_PREFETCH_EN
//                 adds a one-word sequential prefetch buffer.
// Revision      : 1.0
// ============================================================================
module be_native_mem #(
   parameter int BE_ADDR_W  = 8,
   parameter int BE_DATA_W  = 8,
   parameter int MEM_ADDR_W = 6,
   parameter int READ_LAT   = 2,
   parameter int WRITE_LAT  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mem_valid,
   input  logic [BE_ADDR_W-1:0]   mem_addr,
   input  logic [BE_DATA_W-1:0]   mem_wdata,
   input  logic [BE_DATA_W/8-1:0] mem_wstrb,
   output logic [BE_DATA_W-1:0]   mem_rdata,
   output logic                   mem_ready,
   output logic                   busy
);

   localparam int NB        = BE_DATA_W / 8;
   localparam int BE_BYTE_W = $clog2(NB);
   localparam int DEPTH     = 2 ** MEM_ADDR_W;
   localparam int MAX_LAT   = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W     = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] C_RD_LOAD = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] C_WR_LOAD = CNT_W'(WRITE_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [MEM_ADDR_W-1:0] r_idx;
   logic [BE_DATA_W-1:0]  r_wdata;
   logic [NB-1:0]         r_wstrb;
   logic [CNT_W-1:0]      r_cnt;
   logic [BE_DATA_W-1:0]  r_rdata;
   logic                  r_ready;
   logic [BE_DATA_W-1:0]  r_mem [DEPTH];

   logic [MEM_ADDR_W-1:0] w_idx_in;
   logic [MEM_ADDR_W-1:0] w_idx_nxt;
   logic                  w_is_wr_in;
   logic                  w_is_wr;
   logic [CNT_W-1:0]      w_load;
   logic                  w_pf_hit;
   logic [BE_DATA_W-1:0]  w_pf_data;
   logic                  w_unused;

   assign w_idx_in   = mem_addr[BE_BYTE_W +: MEM_ADDR_W];
   assign w_idx_nxt  = r_idx + MEM_ADDR_W'(1);
   assign w_is_wr_in = |mem_wstrb;
   assign w_is_wr    = |r_wstrb;
   assign w_load     = w_is_wr_in ? C_WR_LOAD : C_RD_LOAD;
   assign w_unused   = &{1'b0, mem_addr};

`ifdef BE_MEM_PREFETCH_EN
   logic                  r_pf_valid;
   logic [MEM_ADDR_W-1:0] r_pf_index;
   logic [BE_DATA_W-1:0]  r_pf_data;

   assign w_pf_hit  = r_pf_valid && !w_is_wr_in && (w_idx_in == r_pf_index);
   assign w_pf_data = r_pf_data;
`else
   assign w_pf_hit  = 1'b0;
   assign w_pf_data = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
`ifdef BE_MEM_PREFETCH_EN
         r_pf_valid <= 1'b0;
         r_pf_index <= '0;
         r_pf_data  <= '0;
`endif
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mem_valid) begin
                  r_idx   <= w_idx_in;
                  r_wdata <= mem_wdata;
                  r_wstrb <= mem_wstrb;
                  if (w_pf_hit) begin
                     r_cnt   <= '0;
                     r_state <= S_RESP;
                     r_ready <= 1'b1;
                     r_rdata <= w_pf_data;
                  end else if (w_load == '0) begin
                     r_cnt   <= '0;
                     r_state <= S_RESP;
                     r_ready <= 1'b1;
                     if (!w_is_wr_in) r_rdata <= r_mem[w_idx_in];
                  end else begin
                     r_cnt   <= w_load;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_RESP;
                  r_ready <= 1'b1;
                  if (!w_is_wr) r_rdata <= r_mem[r_idx];
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
`ifdef BE_MEM_PREFETCH_EN
               // Every read primes the buffer with the following word; a write
               // to the buffered word invalidates it regardless of strobes.
               if (!w_is_wr) begin
                  r_pf_valid <= 1'b1;
                  r_pf_index <= w_idx_nxt;
                  r_pf_data  <= r_mem[w_idx_nxt];
               end else if (r_idx == r_pf_index) begin
                  r_pf_valid <= 1'b0;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Writes commit on the edge leaving RESP; an aborted write never gets here.
   always_ff @(posedge clk) begin
      if (r_state == S_RESP && w_is_wr) begin
         for (int b = 0; b < NB; b++) begin
            if (r_wstrb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

   assign mem_rdata = r_rdata;
   assign mem_ready = r_ready;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_be_native_mem.sv
`default_nettype none
// ============================================================================
// tb_be_native_mem : randomized self-checking bench for be_native_mem against
//                    a transaction-level memory/prefetch model.
// Revision         : 1.0
// ============================================================================
module tb_be_native_mem;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MW = 6;
   localparam int RL = 2;
   localparam int WL = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_wstrb;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          busy;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] m_mem [64];
   logic [31:0] m_last;
   bit          m_pfv;
   int          m_pfi;

   be_native_mem #(
      .BE_ADDR_W (AW),
      .BE_DATA_W (DW),
      .MEM_ADDR_W(MW),
      .READ_LAT  (RL),
      .WRITE_LAT (WL)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .mem_valid(mem_valid),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_lat(input int idx, input bit wr);
      if (wr) return WL;
`ifdef BE_MEM_PREFETCH_EN
      if (m_pfv && idx == m_pfi) return 1;
`endif
      return RL;
   endfunction

   function automatic logic [AW-1:0] mk_addr(input int idx);
      logic [1:0] hi;
      logic [1:0] lo;
      hi = 2'($urandom);
      lo = 2'($urandom);
      return {hi, 6'(idx), lo};
   endfunction

   task automatic model_commit(input int idx, input logic [31:0] wd, input logic [3:0] ws);
      if (ws != 4'h0) begin
         for (int b = 0; b < 4; b++)
            if (ws[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
         if (m_pfv && idx == m_pfi) m_pfv = 1'b0;
      end else begin
         m_last = m_mem[idx];
         m_pfv  = 1'b1;
         m_pfi  = (idx + 1) % 64;
      end
   endtask

   task automatic xact(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input bit scramble, output logic [31:0] rd);
      int          idx;
      int          n;
      int          el;
      logic [31:0] ed;
      idx = int'(a[7:2]);
      el  = exp_lat(idx, ws != 4'h0);
      ed  = (ws != 4'h0) ? m_last : m_mem[idx];
      @(negedge clk);
      check_val("idle_before", 32'(busy), 32'd0);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      @(posedge clk); #1;
      n = 1;
      if (scramble) begin
         mem_valid = 1'($urandom);
         mem_addr  = AW'($urandom);
         mem_wdata = $urandom;
         mem_wstrb = 4'($urandom);
      end else begin
         mem_valid = 1'b0;
      end
      while (!mem_ready && n < 16) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("latency", 32'(n), 32'(el));
      check_val("busy_resp", 32'(busy), 32'd1);
      check_val("rdata", mem_rdata, ed);
      rd = mem_rdata;
      mem_valid = 1'b0;
      @(posedge clk); #1;
      check_val("ready_pulse", 32'(mem_ready), 32'd0);
      check_val("bubble_idle", 32'(busy), 32'd0);
      model_commit(idx, wd, ws);
   endtask

   task automatic held_read(input int idx);
      int          cnt;
      int          drain;
      logic [AW-1:0] a;
      cnt   = 0;
      drain = 0;
      a     = mk_addr(idx);
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wstrb = 4'h0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (mem_ready) begin
            cnt++;
            check_val("held_data", mem_rdata, m_mem[idx]);
         end
      end
      mem_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (mem_ready) begin
            drain++;
            check_val("held_drain_data", mem_rdata, m_mem[idx]);
         end
      end
      check_val("held_count", 32'(cnt), 32'd3);
      check_val("held_drain", 32'(drain), 32'd1);
      for (int i = 0; i < 4; i++) model_commit(idx, 32'h0, 4'h0);
   endtask

   task automatic reset_mid_write(input int idx);
      logic [31:0] rd;
      xact(mk_addr(idx), 32'hDEADBEEF, 4'hF, 1'b0, rd);
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = mk_addr(idx);
      mem_wdata = 32'h0BADF00D;
      mem_wstrb = 4'hF;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      @(posedge clk); #1;
      check_val("rst_pre_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_ready", 32'(mem_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("rst_hold_ready", 32'(mem_ready), 32'd0);
         check_val("rst_hold_busy", 32'(busy), 32'd0);
      end
      check_val("rst_rdata", mem_rdata, 32'd0);
      @(negedge clk);
      reset  = 1'b1;
      m_pfv  = 1'b0;
      m_last = 32'd0;
      xact(mk_addr(idx), 32'h0, 4'h0, 1'b0, rd);
      check_val("rst_old_data", rd, 32'hDEADBEEF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic [3:0]  ws;
      int          idx;
      reset     = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      m_last    = 32'd0;
      m_pfv     = 1'b0;
      m_pfi     = 0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_ready", 32'(mem_ready), 32'd0);
      check_val("reset_rdata", mem_rdata, 32'd0);
      check_val("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 64; i++) xact(mk_addr(i), $urandom, 4'hF, 1'b0, rd);

      // Basic byte write / read of byte address 0x10
      xact(10'h010, 32'h0, 4'hF, 1'b0, rd);
      xact(10'h010, 32'h000000A5, 4'h1, 1'b0, rd);
      xact(10'h010, 32'h0, 4'h0, 1'b0, rd);
      check_val("basic_byte", 32'(rd[7:0]), 32'hA5);

      // Partial strobe merge
      xact(10'h020, 32'h11223344, 4'hF, 1'b0, rd);
      xact(10'h020, 32'hFFFFFFFF, 4'b0101, 1'b1, rd);
      xact(10'h320, 32'h0, 4'h0, 1'b0, rd);
      check_val("pstrb_merge", rd, 32'h11FF33FF);

      held_read(12);
      reset_mid_write(20);

      // Sequential reads with wrap, then write invalidation patterns
      xact(mk_addr(62), 32'h0, 4'h0, 1'b0, rd);
      xact(mk_addr(63), 32'h0, 4'h0, 1'b0, rd);
      xact(mk_addr(0),  32'h0, 4'h0, 1'b0, rd);
      xact(mk_addr(1),  32'hCAFE0001, 4'hF, 1'b0, rd);
      xact(mk_addr(1),  32'h0, 4'h0, 1'b0, rd);
      xact(mk_addr(5),  32'h0, 4'h0, 1'b0, rd);
      xact(mk_addr(6),  32'h0000003C, 4'hF, 1'b0, rd);
      xact(mk_addr(6),  32'h0, 4'h0, 1'b0, rd);
      check_val("inval_data", rd, 32'h0000003C);
      xact(mk_addr(9),  32'h0, 4'h0, 1'b0, rd);
      xact(mk_addr(12), 32'h0, 4'h0, 1'b0, rd);

      idx = 0;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 1) == 0) idx = (idx + 1) % 64;
         else idx = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 7);
         ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         xact(mk_addr(idx), $urandom, ws, 1'($urandom), rd);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
